// File: rtl/mdu_issue_ctrl.sv
// Issue/sequencing controller for the shared multiply/divide unit and its HI/LO registers.
// Optional build macro MDU_FLUSH_CANCEL_EN: a flush while busy aborts the in-flight operation.
module mdu_issue_ctrl #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10,
  parameter int unsigned CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid_i,
  input  logic [2:0]       op_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             start_o,
  output logic             divide_o,
  output logic             is_unsigned_o,
  output logic             calc_we_o,
  output logic             hi_we_o,
  output logic             lo_we_o,
  output logic             rd_lo_o,
  output logic [CNT_W-1:0] count_o,
  output logic             busy_o
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               divide_q, divide_d;
  logic               unsigned_q, unsigned_d;
  logic               busy;
  logic               acc;
  logic               count_one;
  logic               abort;

  always_comb begin
    busy      = (state_q == StBusy);
    count_one = (count_q == CNT_W'(1));
`ifdef MDU_FLUSH_CANCEL_EN
    abort     = busy & flush_i;
`else
    abort     = 1'b0;
`endif
    // Ops are only accepted in IDLE, so start/hi_we/lo_we can never fire while busy.
    acc           = ~reset & op_valid_i & ~flush_i & ~busy;
    stall_o       = ~reset & op_valid_i & ~flush_i & busy;
    start_o       = acc & ~op_i[2];
    hi_we_o       = acc & (op_i == 3'b110);
    lo_we_o       = acc & (op_i == 3'b111);
    rd_lo_o       = ~reset & op_valid_i & (op_i[2:1] == 2'b10) & op_i[0];
    calc_we_o     = ~reset & busy & count_one & ~abort;
    count_o       = reset ? '0 : count_q;
    divide_o      = ~reset & divide_q;
    is_unsigned_o = ~reset & unsigned_q;
    busy_o        = ~reset & busy;
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    divide_d   = divide_q;
    unsigned_d = unsigned_q;
    unique case (state_q)
      StIdle: begin
        if (start_o) begin
          count_d    = op_i[1] ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
          divide_d   = op_i[1];
          unsigned_d = op_i[0];
          state_d    = StBusy;
        end
      end
      StBusy: begin
        // The commit cycle (count == 1) is the last busy cycle.
        if (abort || (count_q <= CNT_W'(1))) begin
          count_d = '0;
          state_d = StIdle;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      default: begin
        count_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      count_q    <= '0;
      divide_q   <= 1'b0;
      unsigned_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      divide_q   <= divide_d;
      unsigned_q <= unsigned_d;
    end
  end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Vector-table bench for mdu_issue_ctrl: per-cycle stimulus with expected outputs via a scoreboard.
module tb_mdu_issue_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       op_valid;
  logic [2:0] op;
  logic       flush;
  logic       stall, start, divide, is_unsigned, calc_we, hi_we, lo_we, rd_lo, busy;
  logic [3:0] count;

  always #5 clk = ~clk;

  mdu_issue_ctrl #(
    .MULT_LAT(5),
    .DIV_LAT (10),
    .CNT_W   (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .op_valid_i   (op_valid),
    .op_i         (op),
    .flush_i      (flush),
    .stall_o      (stall),
    .start_o      (start),
    .divide_o     (divide),
    .is_unsigned_o(is_unsigned),
    .calc_we_o    (calc_we),
    .hi_we_o      (hi_we),
    .lo_we_o      (lo_we),
    .rd_lo_o      (rd_lo),
    .count_o      (count),
    .busy_o       (busy)
  );

  // exp bit order: stall start divide is_unsigned calc_we hi_we lo_we rd_lo busy
  typedef struct {
    logic       rst;
    logic       vld;
    logic [2:0] op;
    logic       fl;
    logic [8:0] exp;
    logic [3:0] cnt;
    string      name;
  } vec_t;

  typedef struct {
    logic [8:0] exp;
    logic [3:0] cnt;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic v(input logic rst, input logic vld, input logic [2:0] o, input logic fl,
                   input logic [8:0] e, input logic [3:0] c, input string n);
    vec_t t;
    t.rst = rst; t.vld = vld; t.op = o; t.fl = fl; t.exp = e; t.cnt = c; t.name = n;
    vecs.push_back(t);
  endtask

  initial begin
    exp_t       x;
    logic [8:0] act;

    // Reset: outputs must be gated even with a valid mult presented.
    v(1, 0, 3'b000, 0, 9'b000000000, 0, "rst0");
    v(1, 1, 3'b000, 0, 9'b000000000, 0, "rst_gate");
    // mult latency
    v(0, 1, 3'b000, 0, 9'b010000000, 0, "mult_start");
    for (int i = 5; i >= 2; i--) v(0, 0, 3'b000, 0, 9'b000000001, 4'(i), "mult_cnt");
    v(0, 0, 3'b000, 0, 9'b000010001, 1, "mult_calc");
    v(0, 0, 3'b000, 0, 9'b000000000, 0, "mult_idle");
    // divu with mflo held valid
    v(0, 1, 3'b011, 0, 9'b010000000, 0, "divu_start");
    for (int i = 10; i >= 2; i--) v(0, 1, 3'b101, 0, 9'b101100011, 4'(i), "divu_stall");
    v(0, 1, 3'b101, 0, 9'b101110011, 1, "divu_calc");
    v(0, 1, 3'b101, 0, 9'b001100010, 0, "mflo_go");
    // mthi then mtlo
    v(0, 1, 3'b110, 0, 9'b001101000, 0, "mthi");
    v(0, 1, 3'b111, 0, 9'b001100100, 0, "mtlo");
    v(0, 0, 3'b000, 0, 9'b001100000, 0, "mtx_idle");
    // div with flush at count 4
    v(0, 1, 3'b010, 0, 9'b011100000, 0, "div_start");
    for (int i = 10; i >= 5; i--) v(0, 0, 3'b000, 0, 9'b001000001, 4'(i), "div_cnt");
    v(0, 0, 3'b000, 1, 9'b001000001, 4, "div_flush");
`ifdef MDU_FLUSH_CANCEL_EN
    for (int i = 0; i < 4; i++) v(0, 0, 3'b000, 0, 9'b001000000, 0, "div_aborted");
`else
    v(0, 0, 3'b000, 0, 9'b001000001, 3, "div_cnt");
    v(0, 0, 3'b000, 0, 9'b001000001, 2, "div_cnt");
    v(0, 0, 3'b000, 0, 9'b001010001, 1, "div_calc");
    v(0, 0, 3'b000, 0, 9'b001000000, 0, "div_idle");
`endif
    // flushed mult, then reset mid-multu
    v(0, 1, 3'b000, 1, 9'b001000000, 0, "mult_flushed");
    v(0, 0, 3'b000, 0, 9'b001000000, 0, "flush_idle");
    v(0, 1, 3'b001, 0, 9'b011000000, 0, "multu_start");
    for (int i = 5; i >= 3; i--) v(0, 0, 3'b000, 0, 9'b000100001, 4'(i), "multu_cnt");
    v(1, 0, 3'b000, 0, 9'b000000000, 0, "rst_busy");
    v(0, 0, 3'b000, 0, 9'b000000000, 0, "rst_idle");
    v(0, 0, 3'b000, 0, 9'b000000000, 0, "rst_idle2");
    // back-to-back: second multu stalled through calc cycle
    v(0, 1, 3'b000, 0, 9'b010000000, 0, "b2b_start");
    for (int i = 5; i >= 2; i--) v(0, 1, 3'b001, 0, 9'b100000001, 4'(i), "b2b_stall");
    v(0, 1, 3'b001, 0, 9'b100010001, 1, "b2b_calc");
    v(0, 1, 3'b001, 0, 9'b010000000, 0, "b2b_start2");
    for (int i = 5; i >= 2; i--) v(0, 0, 3'b000, 0, 9'b000100001, 4'(i), "b2b_cnt");
    v(0, 0, 3'b000, 0, 9'b000110001, 1, "b2b_calc2");
    v(0, 0, 3'b000, 0, 9'b000100000, 0, "b2b_idle");

    reset = 1'b1; op_valid = 1'b0; op = 3'b000; flush = 1'b0;
    foreach (vecs[k]) begin
      @(posedge clk);
      #1;
      reset = vecs[k].rst; op_valid = vecs[k].vld; op = vecs[k].op; flush = vecs[k].fl;
      sb.push_back('{exp: vecs[k].exp, cnt: vecs[k].cnt, name: vecs[k].name});
      @(negedge clk);
      x   = sb.pop_front();
      act = {stall, start, divide, is_unsigned, calc_we, hi_we, lo_we, rd_lo, busy};
      total++;
      if (act !== x.exp) begin
        bad++;
        $display("FAIL %s (vec %0d): flags got %b want %b", x.name, k, act, x.exp);
      end
      total++;
      if (count !== x.cnt) begin
        bad++;
        $display("FAIL %s (vec %0d): count got %0d want %0d", x.name, k, count, x.cnt);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_issue_ctrl.md
Name: mdu_issue_ctrl

Overview:
- Issue and sequencing controller for the shared multiply/divide unit (MDU) and its HI/LO registers.
- Sits between the EX-stage instruction decode and the MDU datapath.
- Launches mult/multu/div/divu, models operation latency with a countdown, and commits HI/LO through a write strobe.
- Raises pipeline stall for any MDU-class instruction while an operation is in flight; steers mfhi/mflo/mthi/mtlo.

Parameters:
- MULT_LAT, 5, cycles from launch to HI/LO commit for mult/multu (range 1..2^CNT_W-1).
- DIV_LAT, 10, cycles from launch to HI/LO commit for div/divu (range 1..2^CNT_W-1).
- CNT_W, 4, countdown width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- op_valid  in  1  EX-stage holds an MDU-class instruction
- op  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mfhi, 101 mflo, 110 mthi, 111 mtlo
- flush  in  1  kill the EX-stage instruction this cycle
- stall  out  1  freeze the pipeline at EX
- start  out  1  launch pulse to the MDU; operands are captured this cycle
- divide  out  1  registered: in-flight op is div/divu
- is_unsigned  out  1  registered: in-flight op is multu/divu
- calc_we  out  1  commit the MDU result into HI and LO
- hi_we  out  1  mthi write enable
- lo_we  out  1  mtlo write enable
- rd_lo  out  1  read mux select, 1 = LO, 0 = HI
- count  out  CNT_W  remaining cycles of the in-flight op
- busy  out  1  state == BUSY

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clk.
- Reset: state = IDLE; count, divide, is_unsigned = 0. All outputs are 0 while reset is high.
- Definition: acc = op_valid & ~flush & ~stall.
- States: IDLE and BUSY.
- IDLE, accepted op = mult/multu/div/divu:
  - start = 1 (combinational).
  - Next edge: count = DIV_LAT if op[1] else MULT_LAT; divide = op[1]; is_unsigned = op[0]; state -> BUSY.
- IDLE, accepted op = mthi: hi_we = 1 (combinational, same cycle).
- IDLE, accepted op = mtlo: lo_we = 1 (combinational, same cycle).
- IDLE, op = mfhi/mflo: rd_lo = op[0]; no stall.
- BUSY:
  - Each cycle, count decrements by 1.
  - When count == 1: calc_we = 1 for that cycle; next edge count = 0, state -> IDLE.
  - Latency: start at cycle 0, calc_we at cycle L, IDLE at cycle L+1.
- stall = op_valid & ~flush & (state == BUSY). This includes the calc_we cycle, so an MDU op can be accepted at cycle L+1 at the earliest and reads the committed HI/LO.
- rd_lo still follows op[0] while stalled.
- start, hi_we and lo_we are never asserted while in BUSY.
- At most one of start, hi_we, lo_we is asserted per cycle.
- flush with op_valid: the instruction is ignored (no start, hi_we or lo_we, no stall).
- Reset during BUSY: IDLE on the next edge, calc_we suppressed, count = 0.
- Non-MDU cycles (op_valid = 0): no outputs asserted except the BUSY progression.

Optional Feature:
- Macro: MDU_FLUSH_CANCEL_EN.
- Defined: flush while BUSY aborts the in-flight op. Next edge: state = IDLE, count = 0, no calc_we. If flush coincides with count == 1, calc_we is suppressed.
- Not defined: flush never affects an in-flight op; it only kills the current EX instruction.

Test Plan:
- Reset, then mult accepted at cycle 0 -> start = 1 at cycle 0; count = 5, 4, 3, 2, 1 at cycles 1..5; calc_we = 1 only at cycle 5; busy = 0 at cycle 6.
- divu at cycle 0, mflo held valid from cycle 1 -> is_unsigned = 1, divide = 1; stall = 1 at cycles 1..10; stall = 0 and rd_lo = 1 at cycle 11.
- IDLE, mthi then mtlo on consecutive cycles -> hi_we = 1 at cycle 0, lo_we = 1 at cycle 1, no stall, busy stays 0.
- div running (count = 4), flush = 1 -> with MDU_FLUSH_CANCEL_EN: busy = 0 next cycle, no calc_we. Without: calc_we still at count == 1.
- mult with flush = 1 in the same cycle -> start = 0, busy stays 0. reset at count = 2 -> count = 0, calc_we never asserted.
- mult launched, second multu held valid -> stall through the calc_we cycle; start = 1 exactly one cycle after calc_we, with count reloaded to 5.
